// File: rtl/updown_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with load, clear, wrap/saturate,
// boundary event pulse, sticky overflow and a zero-lag registered compare match.
module updown_mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt,
  input  logic             dir,
  input  logic             ovf_clr,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] q,
  output logic             evt,
  output logic             ovf,
  output logic             match
);

  // Top count held in WIDTH+1 bits so MODULUS = 2**WIDTH never truncates to 0.
  localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] QMAX = MAXV[WIDTH-1:0];

  logic [WIDTH:0]   q_ext, d_ext;
  logic             at_top, at_bot, bnd;
  logic [WIDTH-1:0] q_nxt;
  logic             evt_nxt, ovf_nxt;

  assign q_ext  = {1'b0, q};
  assign d_ext  = {1'b0, d};
  assign at_top = (q_ext == MAXV);
  assign at_bot = (q == '0);

  always_comb begin
    q_nxt   = q;
    bnd     = 1'b0;
    evt_nxt = 1'b0;
    ovf_nxt = ovf & ~ovf_clr;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (ld) begin
      q_nxt = (d_ext > MAXV) ? QMAX : d;
    end else if (cnt) begin
      if (dir) begin
        bnd   = at_top;
        // q < MAXV here, so q+1 cannot carry out of WIDTH bits
        q_nxt = at_top ? (SATURATE ? q : '0) : q + WIDTH'(1);
      end else begin
        bnd   = at_bot;
        q_nxt = at_bot ? (SATURATE ? q : QMAX) : q - WIDTH'(1);
      end
      evt_nxt = bnd;
      // event beats a simultaneous ovf_clr
      ovf_nxt = bnd | (ovf & ~ovf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      evt   <= 1'b0;
      ovf   <= 1'b0;
      match <= 1'b0;
    end else begin
      q     <= q_nxt;
      evt   <= evt_nxt;
      ovf   <= ovf_nxt;
      match <= (q_nxt == cmp_val);
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized + directed bench: three counter configurations against an
// integer-arithmetic reference model (modulo math, clamp, sticky flag).
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, ld, cnt, dir, ovf_clr;
  logic [7:0] d, cmp_val;

  logic [3:0] qa, qb;
  logic [7:0] qc;
  logic       evta, ovfa, mata, evtb, ovfb, matb, evtc, ovfc, matc;

  always #5 clk = ~clk;

  // a: mod-10 wrap, b: mod-10 saturate, c: 8-bit full range wrap
  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d[3:0]), .cnt(cnt),
    .dir(dir), .ovf_clr(ovf_clr), .cmp_val(cmp_val[3:0]),
    .q(qa), .evt(evta), .ovf(ovfa), .match(mata));
  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d[3:0]), .cnt(cnt),
    .dir(dir), .ovf_clr(ovf_clr), .cmp_val(cmp_val[3:0]),
    .q(qb), .evt(evtb), .ovf(ovfb), .match(matb));
  updown_mod_counter #(.WIDTH(8), .MODULUS(64'd256), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d), .cnt(cnt),
    .dir(dir), .ovf_clr(ovf_clr), .cmp_val(cmp_val),
    .q(qc), .evt(evtc), .ovf(ovfc), .match(matc));

  typedef struct {
    int q;
    bit evt;
    bit ovf;
    bit match;
  } mst_t;

  mst_t ma, mb, mc;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mst_t mreset();
    mst_t r;
    r.q = 0; r.evt = 0; r.ovf = 0; r.match = 0;
    return r;
  endfunction

  // Next state from the behavioural rules, using plain modulo arithmetic.
  function automatic mst_t mnext(mst_t s, int m, bit sat, int dv, int cv);
    mst_t r = s;
    bit   ev = 0;
    if (clr) begin
      r.q = 0; r.evt = 0; r.ovf = 0;
    end else begin
      if (ld) r.q = (dv >= m) ? m - 1 : dv;
      else if (cnt) begin
        if (dir) begin
          ev  = (s.q == m - 1);
          r.q = (ev && sat) ? s.q : (s.q + 1) % m;
        end else begin
          ev  = (s.q == 0);
          r.q = (ev && sat) ? s.q : (s.q + m - 1) % m;
        end
      end
      r.evt = ev;
      r.ovf = ev || (s.ovf && !ovf_clr);
    end
    r.match = (r.q == cv);
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_a_q"}, 32'(qa), 32'(ma.q));
    chk({tag, "_a_evt"}, 32'(evta), 32'(ma.evt));
    chk({tag, "_a_ovf"}, 32'(ovfa), 32'(ma.ovf));
    chk({tag, "_a_match"}, 32'(mata), 32'(ma.match));
    chk({tag, "_b_q"}, 32'(qb), 32'(mb.q));
    chk({tag, "_b_evt"}, 32'(evtb), 32'(mb.evt));
    chk({tag, "_b_ovf"}, 32'(ovfb), 32'(mb.ovf));
    chk({tag, "_b_match"}, 32'(matb), 32'(mb.match));
    chk({tag, "_c_q"}, 32'(qc), 32'(mc.q));
    chk({tag, "_c_evt"}, 32'(evtc), 32'(mc.evt));
    chk({tag, "_c_ovf"}, 32'(ovfc), 32'(mc.ovf));
    chk({tag, "_c_match"}, 32'(matc), 32'(mc.match));
  endtask

  // One clock: inputs set by caller before the edge, sampled #1 after it.
  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    ma = mnext(ma, 10, 1'b0, int'(d[3:0]), int'(cmp_val[3:0]));
    mb = mnext(mb, 10, 1'b1, int'(d[3:0]), int'(cmp_val[3:0]));
    mc = mnext(mc, 256, 1'b0, int'(d), int'(cmp_val));
    check_all(tag);
  endtask

  task automatic idle();
    clr = 0; ld = 0; cnt = 0; dir = 1; ovf_clr = 0; d = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cmp_val = '0;
    ma = mreset(); mb = mreset(); mc = mreset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // count up 12 cycles from 0: one wrap at 9->0 on the mod-10 counter
    cnt = 1; dir = 1; cmp_val = 8'd7;
    for (int i = 0; i < 12; i++) begin
      cyc("t1_up");
      if (i == 9) begin
        chk("t1_wrap_q", 32'(qa), 32'd0);
        chk("t1_wrap_evt", 32'(evta), 32'd1);
      end
    end
    chk("t1_ovf_sticky", 32'(ovfa), 32'd1);

    // load 3, count down through 0 -> 9
    idle(); ld = 1; d = 8'd3; cyc("t2_ld");
    idle(); cnt = 1; dir = 0;
    for (int i = 0; i < 5; i++) cyc("t2_dn");
    chk("t2_down_wrap_q", 32'(qa), 32'd8);
    idle(); ld = 1; d = 8'd14; cyc("t2_clamp");
    chk("t2_clamp_q", 32'(qa), 32'd9);

    // saturate at top
    idle(); ld = 1; d = 8'd8; cyc("t3_ld");
    idle(); cnt = 1; dir = 1;
    for (int i = 0; i < 4; i++) cyc("t3_sat");
    chk("t3_sat_q", 32'(qb), 32'd9);
    chk("t3_sat_evt", 32'(evtb), 32'd1);

    // priority: clr > ld > cnt
    idle(); clr = 1; ld = 1; cnt = 1; d = 8'd5; cyc("t4_clr");
    chk("t4_clr_ovf", 32'(ovfa), 32'd0);
    idle(); ld = 1; cnt = 1; d = 8'd5; cyc("t4_ld");
    chk("t4_ld_q", 32'(qa), 32'd5);

    // event and ovf_clr together: set wins; then ovf_clr alone clears
    idle(); ld = 1; d = 8'd9; cyc("t5_ld");
    idle(); cnt = 1; dir = 1; ovf_clr = 1; cyc("t5_both");
    chk("t5_set_wins", 32'(ovfa), 32'd1);
    idle(); ovf_clr = 1; cyc("t5_clr");
    chk("t5_ovf_cleared", 32'(ovfa), 32'd0);

    // 8-bit full range: 255 -> 0 with event
    idle(); ld = 1; d = 8'd255; cyc("t6_ld");
    idle(); cnt = 1; dir = 1; cyc("t6_wrap");
    chk("t6_c_q", 32'(qc), 32'd0);
    chk("t6_c_evt", 32'(evtc), 32'd1);

    // async reset between edges
    cyc("t6_run");
    #2 rst_n = 1'b0;
    #1;
    ma = mreset(); mb = mreset(); mc = mreset();
    check_all("t6_async");
    @(negedge clk) rst_n = 1'b1;
    cyc("t6_resume");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      clr     = ($urandom_range(31) == 0);
      ld      = ($urandom_range(7) == 0);
      cnt     = ($urandom_range(3) != 0);
      dir     = (i / 40) % 2 == 0 ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
      ovf_clr = ($urandom_range(7) == 0);
      d       = 8'($urandom);
      if ($urandom_range(7) == 0) cmp_val = 8'($urandom);
      cyc("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
